// File: rtl/maxpool_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_pkg
// Shared definitions for the sign-magnitude max-pool reducer:
//   - state_t      : window state, EMPTY (no partial window) / ACCUM
//   - sign_idx(n)  : bit index of the sign bit in an n-bit word
//   - mag_msb(n)   : top bit of the magnitude field [n-2:0]
// ---------------------------------------------------------------------------
package maxpool_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int sign_idx(input int n);
        return n - 1;
    endfunction

    function automatic int mag_msb(input int n);
        return n - 2;
    endfunction

endpackage

// File: rtl/maxpool_ctrl_sm_max.sv
// ---------------------------------------------------------------------------
// sm_max
// Combinational sign-magnitude maximum of the running value and a new element.
// Ports:
//   run_data  in  N  current running maximum (kept on an exact tie)
//   new_data  in  N  incoming element
//   max_data  out N  the larger of the two in sign-magnitude order
// Ordering: any sign-0 value beats any sign-1 value (so +0 beats -0);
// among positives the larger magnitude wins, among negatives the smaller.
// ---------------------------------------------------------------------------
module sm_max
    import maxpool_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] run_data,
    input  logic [N-1:0] new_data,
    output logic [N-1:0] max_data
);

    localparam int SIGN_BIT = sign_idx(N);
    localparam int MAG_MSB  = mag_msb(N);

    logic                run_sign_s;
    logic                new_sign_s;
    logic [MAG_MSB:0]    run_mag_s;
    logic [MAG_MSB:0]    new_mag_s;
    logic                take_new_s;

    assign run_sign_s = run_data[SIGN_BIT];
    assign new_sign_s = new_data[SIGN_BIT];
    assign run_mag_s  = run_data[MAG_MSB:0];
    assign new_mag_s  = new_data[MAG_MSB:0];

    // Decide whether the new element replaces the running value; ties keep run.
    always_comb begin
        take_new_s = 1'b0;
        if (run_sign_s != new_sign_s) begin
            take_new_s = ~new_sign_s;
        end else if (run_sign_s == 1'b0) begin
            take_new_s = (new_mag_s > run_mag_s);
        end else begin
            take_new_s = (new_mag_s < run_mag_s);
        end
    end

    assign max_data = take_new_s ? new_data : run_data;

endmodule

// File: rtl/maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl
// Streaming max-pool reducer: folds every WIN consecutive accepted elements
// through a sign-magnitude max and emits one result per window on a
// registered, backpressured output.
// Parameters: N word width (sign at MSB), Q fractional bits (informational),
//             WIN elements per window (>= 1).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous discard of the partial window
//   in_data    in   N-bit sign-magnitude element
//   in_valid   in   in_data valid
//   in_ready   out  element accepted this cycle (combinational)
//   out_data   out  N-bit window maximum (registered)
//   out_valid  out  out_data valid (registered)
//   out_ready  in   downstream accepts out_data
//   busy       out  a partial window is held
// ---------------------------------------------------------------------------
module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int N   = 32,
    parameter int Q   = 16,
    parameter int WIN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    // Reject nonsensical parameterisations at elaboration time.
    if (WIN < 1 || N < 2 || Q < 0 || Q >= N) begin : g_bad_param
        $error("maxpool_ctrl: illegal parameters N=%0d Q=%0d WIN=%0d", N, Q, WIN);
    end

    logic [N-1:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    state_t           state_next_s;
    logic             first_beat_s;
    logic             last_beat_s;
    logic             accept_s;
    logic             complete_s;
    logic [N-1:0]     max_s;
    logic [N-1:0]     result_s;

    assign first_beat_s = (cnt_r == CNT_ZERO);
    assign last_beat_s  = (cnt_r == CNT_LAST);

    // Only the window-completing beat waits for the output register to drain;
    // out_ready feeds in_ready combinationally so the slot can be reused at once.
    assign in_ready   = ~reset & ~clear & ~(last_beat_s & out_valid & ~out_ready);
    assign accept_s   = in_valid & in_ready;
    assign complete_s = accept_s & last_beat_s;

    sm_max #(
        .N (N)
    ) u_sm_max (
        .run_data (acc_r),
        .new_data (in_data),
        .max_data (max_s)
    );

    // The first beat of a window seeds the accumulator without a compare.
    assign result_s = first_beat_s ? in_data : max_s;

    // Next window state from the accepted beat and clear.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s && !last_beat_s) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ACCUM: begin
                if (clear || complete_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Window state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counter and running maximum; clear leaves acc stale on purpose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
            acc_r <= {N{1'b0}};
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            acc_r <= result_s;
            if (last_beat_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Output register: a completing beat loads a new result even in the cycle
    // the previous one is taken, so out_valid stays high across the swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= {N{1'b0}};
            out_valid <= 1'b0;
        end else if (complete_s) begin
            out_data  <= result_s;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state_r == ACCUM);

endmodule

// File: tb/tb_maxpool_ctrl.sv
module tb_maxpool_ctrl;

    localparam int N   = 32;
    localparam int Q   = 16;
    localparam int WIN = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int tests_run = 0;
    int fails     = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    maxpool_ctrl #(.N(N), .Q(Q), .WIN(WIN)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL sb_unexpected: got 0x%08h, expected no output", out_data);
            end else begin
                check("sb_out", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one element; returns #1 after the edge that accepted it.
    task automatic send(input logic [N-1:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_window(input logic [N-1:0] d0, input logic [N-1:0] d1,
                               input logic [N-1:0] d2, input logic [N-1:0] d3,
                               input logic [N-1:0] exp);
        exp_q.push_back(exp);
        send(d0);
        send(d1);
        send(d2);
        send(d3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0000_0000);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Mixed signs, out_valid for exactly one cycle.
        send_window(32'h0001_0000, 32'h8000_8000, 32'h0002_8000, 32'h8001_0000, 32'h0002_8000);
        @(negedge clk);
        check("mixed_valid_first", {31'd0, out_valid}, 32'd1);
        check("mixed_data", out_data, 32'h0002_8000);
        @(negedge clk);
        check("mixed_valid_once", {31'd0, out_valid}, 32'd0);
        idle(1);

        // All negative and signed zeros.
        send_window(32'h8001_0000, 32'h8000_8000, 32'h8002_8000, 32'h8001_0000, 32'h8000_8000);
        idle(2);
        send_window(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        idle(2);

        // Backpressure: two back-to-back windows with out_ready low.
        out_ready = 1'b0;
        send_window(32'h0000_0005, 32'h0000_0009, 32'h8000_0010, 32'h0000_0007, 32'h0000_0009);
        exp_q.push_back(32'h8000_0001);
        send(32'h8000_0003);
        check("bp_hold_data_5", out_data, 32'h0000_0009);
        send(32'h8000_0001);
        check("bp_hold_data_6", out_data, 32'h0000_0009);
        send(32'h8000_0002);
        check("bp_hold_valid_7", {31'd0, out_valid}, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h8000_0004;
        @(negedge clk);
        check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        idle(2);
        @(negedge clk);
        check("bp_stall_ready_late", {31'd0, in_ready}, 32'd0);
        check("bp_stall_data", out_data, 32'h0000_0009);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_swap_valid", {31'd0, out_valid}, 32'd1);
        check("bp_swap_data", out_data, 32'h8000_0001);
        @(negedge clk);
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        idle(1);

        // clear after two beats drops them.
        send(32'h0009_0000);
        send(32'h0008_0000);
        check("clr_busy_before", {31'd0, busy}, 32'd1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0009_0000;
        @(negedge clk);
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("clr_busy_after", {31'd0, busy}, 32'd0);
        clear    = 1'b0;
        in_valid = 1'b0;
        send_window(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 32'h0003_0000);
        idle(3);

        // Asynchronous reset with a pending output and a partial window.
        out_ready = 1'b0;
        send(32'h0000_0011);
        send(32'h0000_0022);
        send(32'h0000_0033);
        send(32'h0000_0044);
        send(32'h0000_0055);
        send(32'h0000_0066);
        check("rst_mid_valid_before", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_out_data", out_data, 32'h0000_0000);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_window(32'h8000_0100, 32'h0000_0042, 32'h0000_0041, 32'h8000_0001, 32'h0000_0042);
        idle(3);

        check("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Streaming max-pool reducer for sign-magnitude fixed-point activations (N-bit word, Q fractional bits, MSB = sign). It accepts a stream of elements over a valid/ready handshake and folds each group of WIN consecutive elements through a sign-magnitude max compare. Each completed window produces one result on a registered output with backpressure. It sits between the convolution output stream and the next layer's input buffer.

## Interface
- N, 32, total word width in bits, including the sign bit.
- Q, 16, fractional bits; informational only, with no effect on the logic.
- WIN, 4, elements per pooling window; must be ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous discard of the partial window.
- in_data  in  N  sign-magnitude input element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts in_data this cycle.
- out_data  out  N  maximum of the completed window.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the downstream block accepts out_data.
- busy  out  1  a partial window is held (cnt ≠ 0).

## Operation
- **Compare rule (sm_max):**
  - Signs differ: the operand with sign 0 wins, so +0 beats −0.
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - Exact tie: the running value is kept.
- **Registers:**
  - acc: N-bit running maximum.
  - cnt: counts 0..WIN−1, width clog2(WIN) with a minimum of 1.
  - out_data / out_valid: the output register.
- **States:**
  - EMPTY (cnt==0) → ACCUM on an accepted beat when WIN>1.
  - ACCUM → EMPTY on the accepted beat with cnt==WIN−1, or on clear.
- **Accepted beat** (in_valid && in_ready):
  - cnt==0: acc ← in_data; no compare.
  - Otherwise: acc ← sm_max(acc, in_data).
  - cnt==WIN−1: out_data ← the final max (the compare result, or in_data when cnt==0 and WIN=1); out_valid ← 1; cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- **in_ready** = !reset && !clear && !(cnt==WIN−1 && out_valid && !out_ready).
  - Partial-window beats are always accepted, even while the output is held.
  - Only the window-completing beat stalls.
  - The combinational path from out_ready to in_ready is intentional.
- **Output handshake:**
  - out_valid && out_ready clears out_valid, unless a completing beat is accepted in the same cycle. In that case out_valid stays 1 and out_data takes the new result.
  - out_data is stable while out_valid && !out_ready.
- **clear:**
  - cnt ← 0; the acc value is don't-care.
  - The pending output is unaffected.
  - in_ready is forced low, so no beat is lost.
- **Reset (asynchronous):** acc=0, cnt=0, out_data=0, out_valid=0, busy=0, in_ready=0 while asserted.
  - Reset mid-window drops the partial window and any pending output.
  - in_ready rises combinationally after deassertion.

## Timing
- Latency: out_valid rises on the edge that accepts the window's last beat, i.e. one cycle after that beat is presented with in_ready=1.
- Throughput: one element per cycle with no bubbles when out_ready=1, giving one result every WIN cycles.
- WIN=1: pass-through with a one-cycle register delay.
- The compare is a single combinational stage; the critical path is the N−1-bit magnitude compare plus a mux.

## Structure
- Package maxpool_pkg holds:
  - the sign-magnitude helpers: sign bit index N−1 and magnitude field [N−2:0];
  - the state enum {EMPTY, ACCUM}.
- Sub-module sm_max (parameter N): purely combinational; inputs run, new; output max, per the compare rule.
- The top-level counter, FSM and output register are roughly 150–200 lines total.

## Test plan
All vectors use N=32, Q=16, WIN=4 unless stated.
- **Mixed signs:** {0x0001_0000 (+1.0), 0x8000_8000 (−0.5), 0x0002_8000 (+2.5), 0x8001_0000 (−1.0)}, out_ready=1 → out_data=0x0002_8000, with out_valid for exactly one cycle, on the edge after the 4th beat.
- **All negative:** {0x8001_0000, 0x8000_8000, 0x8002_8000, 0x8001_0000} → 0x8000_8000 (−0.5).
- **Signed zeros:** {0x8000_0000, 0x0000_0000, 0x8000_0000, 0x8000_0000} → 0x0000_0000.
- **Backpressure:** out_ready=0, two back-to-back windows →
  - the first result is held stable;
  - beats 5–7 are accepted;
  - in_ready=0 on beat 8 until out_ready=1;
  - in that cycle the second result replaces the first, with out_valid continuously 1.
- **clear:** clear after 2 beats → busy=0, in_ready=0 during clear; the next 4 beats {+1.0, +1.0, +1.0, 0x0003_0000} give 0x0003_0000.
- **Reset mid-operation:** reset asserted mid-window and while out_valid=1 → all outputs 0 immediately (asynchronous); a full window after release gives the correct max.
